// File: rtl/heichips25_seq_pkg.sv
// Shared types and constants for the project sequencer: state encoding,
// default timing and the sizing of the shared HOLD/DRAIN counter.
package heichips25_seq_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam int DEF_DRAIN_CYCLES = 2;
  localparam int DEF_RST_HOLD     = 4;

  // The counter only ever holds values up to max-1, so $clog2(max) bits suffice.
  function automatic int cnt_width(input int drain_cycles, input int rst_hold);
    int m;
    int w;
    m = (drain_cycles > rst_hold) ? drain_cycles : rst_hold;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/heichips25_hold_counter.sv
// Loadable down-counter with a zero flag; one instance times both the
// drain window and the reset hold.
module heichips25_hold_counter #(
  parameter int W       = 2,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= W'(RST_VAL);
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/heichips25_project_sequencer.sv
// Project-switch sequencer: retires the active project, gates outputs,
// swaps the select and releases the new project after a reset hold.
//
// state | meaning
// HOLD  | select settled, all projects in reset, outputs gated
// RUN   | active project out of reset, outputs enabled, requests accepted
// DRAIN | old project in reset, outputs gated, select not yet swapped
module heichips25_project_sequencer
  import heichips25_seq_pkg::*;
#(
  parameter int N_PROJ       = 2,
  parameter int SEL_W        = $clog2(N_PROJ),
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int RST_HOLD     = DEF_RST_HOLD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              req_ready,
  output logic [SEL_W-1:0]  active_sel,
  output logic [N_PROJ-1:0] proj_rst_n,
  output logic              out_en,
  output logic              busy,
  output logic              err
);

  localparam int               CNT_W     = cnt_width(DRAIN_CYCLES, RST_HOLD);
  localparam logic [SEL_W:0]   N_PROJ_V  = (SEL_W + 1)'(N_PROJ);
  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(RST_HOLD - 1);

  seq_state_t        state_q, state_d;
  logic [SEL_W-1:0]  pend_q, pend_d;
  logic [SEL_W-1:0]  sel_d;
  logic [N_PROJ-1:0] rst_d;
  logic              run_d;
  logic              err_d;
  logic              in_range;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_load_val;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;

  heichips25_hold_counter #(
    .W       (CNT_W),
    .RST_VAL (RST_HOLD - 1)
  ) u_hold_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign in_range = ({1'b0, req_sel} < N_PROJ_V);

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    sel_d        = active_sel;
    err_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      HOLD: begin
        if (cnt_zero) state_d = RUN;
        else          cnt_dec = 1'b1;
      end
      RUN: begin
        if (req_valid) begin
          if (in_range) begin
            pend_d       = req_sel;
            state_d      = DRAIN;
            cnt_load     = 1'b1;
            cnt_load_val = DRAIN_LD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_zero) begin
          sel_d        = pend_q;
          state_d      = HOLD;
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase

    // Outputs are computed from the next state and registered, so every
    // reset bit is a plain flop output with no decode glitches.
    run_d = (state_d == RUN);
    rst_d = '0;
    for (int i = 0; i < N_PROJ; i++) begin
      rst_d[i] = run_d && (sel_d == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOLD;
      pend_q     <= '0;
      active_sel <= '0;
      proj_rst_n <= '0;
      out_en     <= 1'b0;
      req_ready  <= 1'b0;
      busy       <= 1'b1;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      active_sel <= sel_d;
      proj_rst_n <= rst_d;
      out_en     <= run_d;
      req_ready  <= run_d;
      busy       <= !run_d;
      err        <= err_d;
    end
  end

endmodule

// File: doc/heichips25_project_sequencer.md
# heichips25_project_sequencer

Sequencing controller for the shared multi-project tile: owns the project-select index, the per-project resets and the output gate. On a switch request it retires the active project, holds the outputs quiet, swaps the select and releases the new project from reset after a fixed hold. The wrapper's output muxes consume `active_sel` and `out_en`; the projects consume `proj_rst_n`.

## Interface
Parameters:
- `N_PROJ`, default 2: number of projects, must be ≥ 2.
- `SEL_W`, default `$clog2(N_PROJ)`: select width.
- `DRAIN_CYCLES`, default 2: gated cycles before the select changes, must be ≥ 1.
- `RST_HOLD`, default 4: cycles the new project is held in reset after the select changes, must be ≥ 1.

Ports:
- `clk` in 1: clock; the only clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: switch request strobe.
- `req_sel` in `SEL_W`: requested project index.
- `req_ready` out 1: high only in RUN; a request is accepted on any edge with `req_valid & req_ready`.
- `active_sel` out `SEL_W`: select for the wrapper's output muxes.
- `proj_rst_n` out `N_PROJ`: per-project active-low reset.
- `out_en` out 1: when low, the wrapper forces `uo_out`, `uio_out` and `uio_oe` to 0.
- `busy` out 1: high when the state is not RUN.
- `err` out 1: one-cycle pulse on acceptance of an out-of-range index.

## Operation
- States: HOLD, RUN, DRAIN. A single down-counter `cnt` serves both HOLD and DRAIN.
- Reset, asynchronous:
  - state=HOLD, `cnt`=RST_HOLD-1, `active_sel`=0.
  - `proj_rst_n`=all 0, `out_en`=0, `busy`=1, `req_ready`=0, `err`=0.
- HOLD:
  - `proj_rst_n`=all 0, `out_en`=0.
  - Decrement `cnt`; when `cnt`=0, go to RUN.
  - On entry to RUN, `proj_rst_n[active_sel]`=1 and `out_en`=1.
- RUN:
  - Exactly one bit of `proj_rst_n` is high, the one at `active_sel`. All other bits stay 0.
  - On acceptance with `req_sel` < N_PROJ: latch `req_sel` into `pend_sel`, go to DRAIN with `cnt`=DRAIN_CYCLES-1. On the same edge, `proj_rst_n`=all 0 and `out_en`=0.
  - On acceptance with `req_sel` ≥ N_PROJ: stay in RUN, pulse `err` for one cycle, leave all outputs unchanged.
  - A request with `req_sel == active_sel` is legal. It runs the full sequence, so it acts as a project restart.
- DRAIN:
  - Outputs stay gated.
  - Decrement `cnt`; when `cnt`=0, load `active_sel`←`pend_sel`, go to HOLD with `cnt`=RST_HOLD-1.
- `req_valid` outside RUN is ignored, not queued. The requester must hold `req_valid` until it sees `req_ready`.
- All outputs are registered. There is no combinational path from request inputs to any output.
- `proj_rst_n` bits are glitch-free flop outputs, because they drive resets.

## Timing
- After `rst_n` rises, the first edge is edge 1. `out_en`, `proj_rst_n[0]` and `req_ready` go high after edge RST_HOLD.
- For a request accepted on edge k:
  - Edge k: `out_en`, `req_ready` and the old reset bit go low.
  - Edge k+DRAIN_CYCLES: `active_sel` changes.
  - Edge k+DRAIN_CYCLES+RST_HOLD: new reset bit, `out_en` and `req_ready` go high.
  - Gated window = DRAIN_CYCLES+RST_HOLD cycles; defaults give 6.
- The select never changes while `out_en`=1. The old and new reset bits are never both high.
- Earliest next acceptance: edge k+DRAIN_CYCLES+RST_HOLD+1.
- `rst_n` asserted mid-DRAIN or mid-HOLD aborts immediately to the reset values. `pend_sel` is discarded and `active_sel` returns to 0.

## Structure
- Package `heichips25_seq_pkg` holds:
  - the `seq_state_t` enum {HOLD, RUN, DRAIN};
  - the default DRAIN_CYCLES and RST_HOLD constants;
  - a helper function giving the `cnt` width, `$clog2(max(DRAIN_CYCLES,RST_HOLD))`, minimum 1.
- Sub-module `heichips25_hold_counter`: loadable down-counter with a `zero` flag, shared by HOLD and DRAIN.
- The output muxes stay in the wrapper, gated by `out_en`.

## Test plan
- **Reset release:** deassert `rst_n`, no requests (defaults). Required: `proj_rst_n`=2'b00 for edges 1–3; 2'b01 from edge 4; `out_en`=1 and `req_ready`=1 from edge 4; `active_sel`=0.
- **Switch 0→1:** `req_valid`=1, `req_sel`=1 accepted at edge k. Required: `out_en`=0 and `proj_rst_n`=2'b00 at k; `active_sel`=1 at k+2; `proj_rst_n`=2'b10 and `out_en`=1 at k+6; `busy` high for exactly 6 cycles.
- **Restart:** in RUN with `active_sel`=1, request `req_sel`=1. Required: same 6-cycle gated sequence; `active_sel` stays 1; `proj_rst_n[1]` low for 6 cycles.
- **Out-of-range:** with N_PROJ=3, request `req_sel`=3. Required: `err`=1 for exactly one cycle; state stays RUN; `proj_rst_n` and `active_sel` unchanged.
- **Busy-time request:** pulse `req_valid` with `req_sel`=0 during DRAIN. Required: ignored, target stays 1. Holding `req_valid` until `req_ready` gives acceptance on the first RUN edge.
- **Mid-switch reset:** assert `rst_n` at edge k+3 of a 0→1 switch. Required: immediate `active_sel`=0 and all outputs at their reset values; after release, project 0 comes up after RST_HOLD edges.
